// File: rtl/secure_rx_decoder_if.sv
// Serial Hamming(7,4) receive port plus decoded result and error counters.
// The master drives the serial bits; the slave is the decoder.
interface secure_rx_decoder_if #(
  parameter int CNT_W = 8
);
  logic             data_in;
  logic             strobe_in;
  logic [3:0]       data_out;
  logic             valid_out;
  logic             corrected;
  logic [2:0]       syndrome;
  logic             frame_err;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] ferr_count;

  modport master (
    output data_in, strobe_in,
    input  data_out, valid_out, corrected,
    input  syndrome, frame_err,
    input  corr_count, ferr_count
  );

  modport slave (
    input  data_in, strobe_in,
    output data_out, valid_out, corrected,
    output syndrome, frame_err,
    output corr_count, ferr_count
  );
endinterface

// File: rtl/secure_rx_decoder.sv
// Serial Hamming(7,4) frame receiver with single-bit correction.
// Decodes on the 7th bit so the result is registered one clock later.
module secure_rx_decoder #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  secure_rx_decoder_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DECODE
  } state_e;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [6:0]       sr_q, sr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [3:0]       dout_q, dout_d;
  logic [2:0]       syn_q, syn_d;
  logic             vld_q, vld_d;
  logic             corr_q, corr_d;
  logic             ferr_q, ferr_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  logic [6:0] frame;
  logic [6:0] flip;
  logic [6:0] fixed;
  logic [2:0] syn;

  // Syndrome and correction of the word completed by this cycle's bit
  always_comb begin
    frame  = {sr_q[5:0], bus.data_in};
    syn[0] = frame[6] ^ frame[4] ^ frame[2] ^ frame[0];
    syn[1] = frame[5] ^ frame[4] ^ frame[1] ^ frame[0];
    syn[2] = frame[3] ^ frame[2] ^ frame[1] ^ frame[0];
    case (syn)
      3'd1:    flip = 7'b1000000;
      3'd2:    flip = 7'b0100000;
      3'd3:    flip = 7'b0010000;
      3'd4:    flip = 7'b0001000;
      3'd5:    flip = 7'b0000100;
      3'd6:    flip = 7'b0000010;
      3'd7:    flip = 7'b0000001;
      default: flip = 7'b0000000;
    endcase
    fixed = frame ^ flip;
  end

  // Next state, shifting, result capture and counters
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    syn_d   = syn_q;
    vld_d   = 1'b0;
    corr_d  = 1'b0;
    ferr_d  = 1'b0;
    ccnt_d  = ccnt_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE, DECODE: begin
        if (bus.strobe_in) begin
          state_d = SHIFT;
          sr_d    = {6'b0, bus.data_in};
          cnt_d   = 3'd1;
        end else begin
          state_d = IDLE;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!bus.strobe_in) begin
          state_d = IDLE;
          sr_d    = '0;
          cnt_d   = '0;
          ferr_d  = 1'b1;
          if (fcnt_q != CMAX) fcnt_d = fcnt_q + ONE;
        end else if (cnt_q == 3'd6) begin
          state_d = DECODE;
          sr_d    = frame;
          cnt_d   = 3'd7;
          dout_d  = {fixed[4], fixed[2], fixed[1], fixed[0]};
          syn_d   = syn;
          vld_d   = 1'b1;
          corr_d  = (syn != 3'd0);
          if (corr_d && ccnt_q != CMAX) ccnt_d = ccnt_q + ONE;
        end else begin
          sr_d  = frame;
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      syn_q   <= '0;
      vld_q   <= 1'b0;
      corr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ccnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      syn_q   <= syn_d;
      vld_q   <= vld_d;
      corr_q  <= corr_d;
      ferr_q  <= ferr_d;
      ccnt_q  <= ccnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.syndrome   = syn_q;
  assign bus.valid_out  = vld_q;
  assign bus.corrected  = corr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.corr_count = ccnt_q;
  assign bus.ferr_count = fcnt_q;
endmodule
